// File: rtl/packet_merge_arb.sv
// packet_merge_arb: two-into-one merge stage for router packets.
// Each input is buffered in a small FIFO. A round-robin arbiter picks a
// non-empty FIFO whenever the registered output stage can load, and the
// packet bits pass through unmodified.
// Optional feature macro: MERGE_STATS_EN adds saturating per-input grant
// counters (grant_cnt0 / grant_cnt1).
module packet_merge_arb #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in0_valid,
  input  logic [WIDTH-1:0] in0_data,
  output logic             in0_ready,
  input  logic             in1_valid,
  input  logic [WIDTH-1:0] in1_data,
  output logic             in1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
`ifdef MERGE_STATS_EN
  ,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] C_FULL = (AW + 1)'(DEPTH);

  // Elaboration-time sanity check of the configuration.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CNT_W < 1) begin : g_bad_cfg
    $error("packet_merge_arb: DEPTH must be a power of two >= 2 and CNT_W >= 1");
  end

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_out_data;
  logic             r_rr;
  logic             r_live;

  logic [WIDTH-1:0] r_mem  [2][DEPTH];
  logic [AW-1:0]    r_wptr [2];
  logic [AW-1:0]    r_rptr [2];
  logic [AW:0]      r_cnt  [2];

  logic [WIDTH-1:0] w_in_data [2];
  logic [1:0]       w_in_valid;
  logic [1:0]       w_ready;
  logic [1:0]       w_push;
  logic [1:0]       w_pop;
  logic [1:0]       w_ne;
  logic             w_any;
  logic             w_gnt;
  logic             w_load;

  // Input mapping, FIFO status and round-robin grant selection.
  always_comb begin
    w_in_data[0]  = in0_data;
    w_in_data[1]  = in1_data;
    w_in_valid    = {in1_valid, in0_valid};
    for (int unsigned i = 0; i < 2; i++) begin
      // Ready comes only from the registered count, so a pop in the same
      // cycle never opens a full FIFO; r_live keeps it low through reset.
      w_ready[i] = r_live && (r_cnt[i] != C_FULL);
      w_ne[i]    = (r_cnt[i] != '0);
    end
    w_push = w_in_valid & w_ready;
    w_any  = |w_ne;
    w_gnt  = (w_ne[0] && w_ne[1]) ? r_rr : w_ne[1];
    w_load = (r_state == S_EMPTY) || out_ready;
    w_pop  = '0;
    if (w_load && w_any) begin
      w_pop[0] = !w_gnt;
      w_pop[1] = w_gnt;
    end
  end

  // Ready enable: low during reset, high from the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_live <= 1'b0;
    end else begin
      r_live <= 1'b1;
    end
  end

  // FIFO storage writes (contents need no reset; count gates visibility).
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 2; i++) begin
      if (w_push[i]) begin
        r_mem[i][r_wptr[i]] <= w_in_data[i];
      end
    end
  end

  // FIFO pointers and occupancy counts; pointers wrap modulo DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 2; i++) begin
        r_wptr[i] <= '0;
        r_rptr[i] <= '0;
        r_cnt[i]  <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (w_push[i]) begin
          r_wptr[i] <= r_wptr[i] + 1'b1;
        end
        if (w_pop[i]) begin
          r_rptr[i] <= r_rptr[i] + 1'b1;
        end
        if (w_push[i] && !w_pop[i]) begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end else if (!w_push[i] && w_pop[i]) begin
          r_cnt[i] <= r_cnt[i] - 1'b1;
        end
      end
    end
  end

  // Output stage FSM: load the granted FIFO head and flip the rr pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_EMPTY;
      r_out_data <= '0;
      r_rr       <= 1'b0;
    end else if (w_load) begin
      if (w_any) begin
        r_out_data <= r_mem[w_gnt][r_rptr[w_gnt]];
        r_state    <= S_FULL;
        r_rr       <= !w_gnt;
      end else begin
        r_state <= S_EMPTY;
      end
    end
  end

  assign in0_ready = w_ready[0];
  assign in1_ready = w_ready[1];
  assign out_valid = (r_state == S_FULL);
  assign out_data  = r_out_data;

`ifdef MERGE_STATS_EN
  logic [CNT_W-1:0] r_gcnt0;
  logic [CNT_W-1:0] r_gcnt1;

  // Saturating grant counters, one increment per load granted to an input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gcnt0 <= '0;
      r_gcnt1 <= '0;
    end else begin
      if (w_pop[0] && (r_gcnt0 != '1)) begin
        r_gcnt0 <= r_gcnt0 + 1'b1;
      end
      if (w_pop[1] && (r_gcnt1 != '1)) begin
        r_gcnt1 <= r_gcnt1 + 1'b1;
      end
    end
  end

  assign grant_cnt0 = r_gcnt0;
  assign grant_cnt1 = r_gcnt1;
`endif

endmodule
